// File: rtl/mix_columns_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : mix_columns_seq_if
//  Brief    : Valid/ready input and output channels of the sequential
//             AES MixColumns / InvMixColumns engine.
//  Revision : 1.0  initial release
// ============================================================================
interface mix_columns_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_inverse;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    // Producer/consumer side: drives states in, takes results out
    modport master (
        output in_valid, in_state, in_inverse, in_bypass, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    // Engine side
    modport slave (
        input  in_valid, in_state, in_inverse, in_bypass, out_ready,
        output in_ready, out_valid, out_state, busy
    );
endinterface
`default_nettype wire

// File: rtl/mix_columns_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mix_columns_seq
//  Brief    : Sequential AES MixColumns / InvMixColumns engine. LANES column
//             mixers process LANES columns per cycle, in place, over
//             K = 4/LANES cycles. Per-transaction bypass passes the state
//             through in one cycle (final round).
//  Revision : 1.0  initial release
// ============================================================================
module mix_columns_seq #(
    parameter int LANES = 1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mix_columns_seq_if.slave   bus
);

    localparam int         K            = 4 / LANES;
    localparam logic [1:0] c_STEP       = 2'(LANES);
    // Counter value at the start of the final BUSY cycle
    localparam logic [1:0] c_LAST       = 2'((K - 1) * LANES);

    localparam logic [1:0] c_STATE_IDLE = 2'd0;
    localparam logic [1:0] c_STATE_BUSY = 2'd1;
    localparam logic [1:0] c_STATE_DONE = 2'd2;

    // Only whole-column splits of the 4-column state are supported
    if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
        $error("mix_columns_seq: LANES must be 1, 2 or 4");
    end

    // GF(2^8) multiply by x, reduced modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // One column through the forward {02,03,01,01} or inverse
    // {0e,0b,0d,09} circulant matrix; byte 0 is the MSB
    function automatic logic [31:0] mix_col(input logic [31:0] col,
                                            input logic        inv);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] b;
        mix_col = '0;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31 - 8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
        end
        for (int i = 0; i < 4; i++) begin
            if (inv) begin
                b = (x8[i]         ^ x4[i]         ^ x2[i])              // 0e
                  ^ (x8[(i+1)%4]   ^ x2[(i+1)%4]   ^ a[(i+1)%4])         // 0b
                  ^ (x8[(i+2)%4]   ^ x4[(i+2)%4]   ^ a[(i+2)%4])         // 0d
                  ^ (x8[(i+3)%4]   ^ a[(i+3)%4]);                        // 09
            end else begin
                b = x2[i]                                                // 02
                  ^ (x2[(i+1)%4] ^ a[(i+1)%4])                           // 03
                  ^ a[(i+2)%4]                                           // 01
                  ^ a[(i+3)%4];                                          // 01
            end
            mix_col[31 - 8*i -: 8] = b;
        end
    endfunction

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [127:0]      r_work;
    logic [1:0]        r_cnt;
    logic              r_inverse;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_busy;
    logic              w_accept;

    logic [3:0][31:0]  w_cols;
    logic [3:0][31:0]  w_mixed;
    logic [1:0]        w_lane_idx [LANES];
    logic [31:0]       w_lane_out [LANES];

    assign w_accept      = bus.in_valid && w_in_ready;
    assign w_cols        = r_work;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.out_state = r_work;

    // One column mixer per lane; lane l works on column r_cnt + l
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_lane_idx[l] = r_cnt + 2'(l);
        // Column c sits at packed index 3-c, which is ~c for 2-bit c
        assign w_lane_out[l] = mix_col(w_cols[~w_lane_idx[l]], r_inverse);
    end

    // Working state with this cycle's columns replaced by their mixed value
    always_comb begin
        w_mixed = w_cols;
        for (int l = 0; l < LANES; l++) begin
            w_mixed[~w_lane_idx[l]] = w_lane_out[l];
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_STATE_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state: accept leads to BUSY, or straight to DONE on bypass
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_STATE_IDLE: begin
                if (w_accept) begin
                    w_next_state = bus.in_bypass ? c_STATE_DONE : c_STATE_BUSY;
                end
            end
            c_STATE_BUSY: begin
                if (r_cnt == c_LAST) begin
                    w_next_state = c_STATE_DONE;
                end
            end
            c_STATE_DONE: begin
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        w_next_state = bus.in_bypass ? c_STATE_DONE : c_STATE_BUSY;
                    end else begin
                        w_next_state = c_STATE_IDLE;
                    end
                end
            end
            default: w_next_state = c_STATE_IDLE;
        endcase
    end

    // FSM outputs; in_ready in DONE follows out_ready for back-to-back accepts
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            c_STATE_IDLE: w_in_ready = 1'b1;
            c_STATE_BUSY: w_busy     = 1'b1;
            c_STATE_DONE: begin
                w_out_valid = 1'b1;
                w_in_ready  = bus.out_ready;
            end
            default: ;
        endcase
    end

    // Datapath: load on accept, mix LANES columns per BUSY cycle in place
    always_ff @(posedge clk) begin
        if (reset) begin
            r_work    <= '0;
            r_cnt     <= '0;
            r_inverse <= 1'b0;
        end else if (w_accept) begin
            r_work    <= bus.in_state;
            r_cnt     <= '0;
            r_inverse <= bus.in_inverse;
        end else if (r_state == c_STATE_BUSY) begin
            r_work    <= w_mixed;
            r_cnt     <= r_cnt + c_STEP;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mix_columns_seq
//  Brief    : Scoreboard bench for mix_columns_seq with LANES = 1, 2, 4.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mix_columns_seq;

    logic clk = 1'b0;
    logic drv_reset;
    always #5 clk = ~clk;

    logic [2:0]   drv_valid, drv_inv, drv_byp, drv_oready;
    logic [127:0] drv_state [3];

    mix_columns_seq_if u_if1 ();
    mix_columns_seq_if u_if2 ();
    mix_columns_seq_if u_if4 ();

    assign u_if1.in_valid = drv_valid[0];  assign u_if1.in_state = drv_state[0];
    assign u_if1.in_inverse = drv_inv[0];  assign u_if1.in_bypass = drv_byp[0];
    assign u_if1.out_ready = drv_oready[0];
    assign u_if2.in_valid = drv_valid[1];  assign u_if2.in_state = drv_state[1];
    assign u_if2.in_inverse = drv_inv[1];  assign u_if2.in_bypass = drv_byp[1];
    assign u_if2.out_ready = drv_oready[1];
    assign u_if4.in_valid = drv_valid[2];  assign u_if4.in_state = drv_state[2];
    assign u_if4.in_inverse = drv_inv[2];  assign u_if4.in_bypass = drv_byp[2];
    assign u_if4.out_ready = drv_oready[2];

    wire [2:0] obs_ready = {u_if4.in_ready,  u_if2.in_ready,  u_if1.in_ready};
    wire [2:0] obs_valid = {u_if4.out_valid, u_if2.out_valid, u_if1.out_valid};
    wire [2:0] obs_busy  = {u_if4.busy,      u_if2.busy,      u_if1.busy};
    wire [127:0] obs_state [3];
    assign obs_state[0] = u_if1.out_state;
    assign obs_state[1] = u_if2.out_state;
    assign obs_state[2] = u_if4.out_state;

    mix_columns_seq #(.LANES(1)) u_dut1 (.clk(clk), .reset(drv_reset), .bus(u_if1.slave));
    mix_columns_seq #(.LANES(2)) u_dut2 (.clk(clk), .reset(drv_reset), .bus(u_if2.slave));
    mix_columns_seq #(.LANES(4)) u_dut4 (.clk(clk), .reset(drv_reset), .bus(u_if4.slave));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int sel      = 0;
    logic rand_stall = 1'b0;

    typedef struct {
        logic [127:0] exp;
        int           acc;
        int           lat;
    } txn_t;
    txn_t sb [$];
    logic [127:0] last_out;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (lane set %0d, cycle %0d)", tag, obs, exp, sel, cyc);
        end
    endtask

    // Reference model: shift-and-add GF(2^8) multiply and explicit matrix rows
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] st, input logic inv, input logic byp);
        logic [7:0] fwd [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
        logic [7:0] rev [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        logic [7:0] acc;
        logic [127:0] r = st;
        if (byp) return st;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gmul(inv ? rev[(j - row + 4) % 4] : fwd[(j - row + 4) % 4],
                                     st[127 - 32*c - 8*j -: 8]);
                end
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic int k_of(input int s);
        return (s == 0) ? 4 : (s == 1) ? 2 : 1;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Monitor on the falling edge: handshake rules, stall stability, scoreboard
    initial begin : p_monitor
        logic stalled = 1'b0;
        logic lat_done = 1'b0;
        logic exp_rdy;
        logic [127:0] held = '0;
        forever begin
            @(negedge clk);
            if (drv_reset) begin
                sb.delete();
                stalled  = 1'b0;
                lat_done = 1'b0;
            end else begin
                exp_rdy = (!obs_busy[sel] && !obs_valid[sel]) || (obs_valid[sel] && drv_oready[sel]);
                check("in_ready", 128'(obs_ready[sel]), 128'(exp_rdy));
                if (stalled) begin
                    check("stall_valid", 128'(obs_valid[sel]), 128'(1));
                    check("stall_state", obs_state[sel], held);
                    stalled = 1'b0;
                end
                if (obs_valid[sel]) begin
                    if (sb.size() == 0) begin
                        check("spurious_valid", 128'(obs_valid[sel]), 128'(0));
                    end else begin
                        if (!lat_done) begin
                            check("latency", 128'(cyc), 128'(sb[0].acc + sb[0].lat));
                            lat_done = 1'b1;
                        end
                        if (drv_oready[sel]) begin
                            check("out_state", obs_state[sel], sb[0].exp);
                            last_out = obs_state[sel];
                            void'(sb.pop_front());
                            lat_done = 1'b0;
                        end else begin
                            stalled = 1'b1;
                            held    = obs_state[sel];
                        end
                    end
                end
                if (drv_valid[sel] && obs_ready[sel]) begin
                    sb.push_back('{exp: model(drv_state[sel], drv_inv[sel], drv_byp[sel]),
                                   acc: cyc + 1,
                                   lat: drv_byp[sel] ? 0 : k_of(sel)});
                end
            end
        end
    end

    // Random consumer stalls during the regression phase
    initial begin : p_stall
        forever begin
            @(posedge clk);
            #1;
            if (rand_stall) drv_oready[sel] = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one state and return the edge number on which it was accepted
    task automatic send(input int s, input logic [127:0] st, input logic inv,
                        input logic byp, output int acc_edge);
        int guard = 0;
        drv_state[s] = st;
        drv_inv[s]   = inv;
        drv_byp[s]   = byp;
        drv_valid[s] = 1'b1;
        #1;
        while (!obs_ready[s] && guard < 200) begin
            @(posedge clk);
            #1;
            #1;
            guard++;
        end
        if (guard >= 200) check("accept_timeout", 128'(obs_ready[s]), 128'(1));
        @(posedge clk);
        #1;
        acc_edge     = cyc;
        drv_valid[s] = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 500) begin
            tick(1);
            guard++;
        end
        if (sb.size() != 0) check("drain_timeout", 128'(sb.size()), 128'(0));
    endtask

    initial begin : p_main
        int a1, a2, g;
        logic [127:0] x;
        drv_valid  = '0;
        drv_inv    = '0;
        drv_byp    = '0;
        drv_oready = '0;
        for (int s = 0; s < 3; s++) drv_state[s] = '0;
        drv_reset = 1'b1;
        tick(3);
        for (int s = 0; s < 3; s++) begin
            check("rst_out_valid", 128'(obs_valid[s]), 128'(0));
            check("rst_busy",      128'(obs_busy[s]),  128'(0));
            check("rst_in_ready",  128'(obs_ready[s]), 128'(1));
            check("rst_out_state", obs_state[s], 128'(0));
        end
        drv_reset = 1'b0;

        for (int s = 0; s < 3; s++) begin
            sel = s;
            drv_oready[s] = 1'b1;
            tick(1);

            send(s, 128'hdb135345_f20a225c_01010101_2d26314c, 1'b0, 1'b0, a1);
            drain();
            check("fips_fwd", last_out, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8);

            send(s, 128'h8e4da1bc_9fdc589d_c6c6c6c6_d5d5d7d6, 1'b1, 1'b0, a1);
            drain();
            check("fips_inv", last_out, 128'hdb135345_f20a225c_c6c6c6c6_d4d4d4d5);

            // Bypass followed immediately by a mixed state
            x = rnd128();
            send(s, x, 1'b0, 1'b1, a1);
            send(s, rnd128(), 1'b1, 1'b0, a2);
            check("b2b_gap", 128'(a2 - a1), 128'(1));
            drain();

            // Backpressure with input toggling while the engine works
            drv_oready[s] = 1'b0;
            send(s, rnd128(), 1'b0, 1'b0, a1);
            g = 0;
            while (!obs_valid[s] && g < 20) begin
                drv_state[s] = rnd128();
                drv_inv[s]   = ~drv_inv[s];
                tick(1);
                g++;
            end
            for (int i = 0; i < 10; i++) begin
                drv_state[s] = rnd128();
                drv_inv[s]   = ~drv_inv[s];
                tick(1);
            end
            drv_oready[s] = 1'b1;
            drain();

            // Reset during the second BUSY cycle discards the transaction
            if (s == 0) begin
                send(s, rnd128(), 1'b0, 1'b0, a1);
                tick(1);
                drv_reset = 1'b1;
                tick(1);
                check("midrst_out_valid", 128'(obs_valid[s]), 128'(0));
                check("midrst_out_state", obs_state[s], 128'(0));
                check("midrst_in_ready",  128'(obs_ready[s]), 128'(1));
                check("midrst_busy",      128'(obs_busy[s]), 128'(0));
                drv_reset = 1'b0;
                send(s, 128'hdb135345_f20a225c_01010101_2d26314c, 1'b0, 1'b0, a1);
                drain();
                check("midrst_follow", last_out, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8);
            end

            // Random regression with consumer stalls
            rand_stall = 1'b1;
            for (int i = 0; i < 1000; i++) begin
                send(s, rnd128(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), a1);
                if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
            end
            rand_stall = 1'b0;
            drv_oready[s] = 1'b1;
            drain();

            // Inverse undoes forward through the engine itself
            for (int i = 0; i < 10; i++) begin
                x = rnd128();
                send(s, x, 1'b0, 1'b0, a1);
                drain();
                send(s, last_out, 1'b1, 1'b0, a1);
                drain();
                check("roundtrip", last_out, x);
            end
            drv_oready[s] = 1'b0;
            tick(2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
